prog_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the single-cycle CPU. It receives a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words. It writes them sequentially into instruction memory from address 0, verifies an XOR checksum, and then releases the CPU from reset. Until a load completes successfully, the CPU is held in reset.

---
 rtl/prog_loader.sv | 135 +++++++++++++
 tb/tb_prog_loader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a byte stream,
// writes them to instruction memory from address 0, verifies an XOR checksum and releases the CPU.
module prog_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W    = ADDR_W + 1;
  localparam int unsigned CAPACITY = 1 << ADDR_W;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_CSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [7:0]       lenHi;
  logic [7:0]       dataHi;
  logic [7:0]       runXor;
  logic [CNT_W-1:0] wordTotal;

  logic             accept;
  logic [15:0]      lenWord;
  logic             lenTooBig;
  logic [CNT_W-1:0] wordsInc;
  logic             lastWord;

  // A start pulse always wins over a coincident byte, which is then dropped.
  assign accept    = in_valid && in_ready && !start;
  assign lenWord   = {lenHi, in_data};
  assign lenTooBig = 32'(lenWord) > CAPACITY;
  assign wordsInc  = words_loaded + CNT_W'(1);
  assign lastWord  = (wordsInc == wordTotal);

  always_comb begin
    stateNext = state;
    if (start) begin
      stateNext = ST_LEN_HI;
    end else if (accept) begin
      case (state)
        ST_LEN_HI:  stateNext = ST_LEN_LO;
        ST_LEN_LO: begin
          if (lenTooBig)              stateNext = ST_ERROR;
          else if (lenWord == 16'd0)  stateNext = ST_CSUM;
          else                        stateNext = ST_DATA_HI;
        end
        ST_DATA_HI: stateNext = ST_DATA_LO;
        ST_DATA_LO: stateNext = lastWord ? ST_CSUM : ST_DATA_HI;
        ST_CSUM:    stateNext = ((runXor ^ in_data) == 8'h00) ? ST_DONE : ST_ERROR;
        default:    stateNext = state;
      endcase
    end
  end

  // Status outputs are registered decodes of the next state so they line up with it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      cpu_run      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
      lenHi        <= '0;
      dataHi       <= '0;
      runXor       <= '0;
      wordTotal    <= '0;
    end else begin
      state    <= stateNext;
      in_ready <= stateNext inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};
      busy     <= stateNext inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};
      cpu_run  <= (stateNext == ST_DONE);
      done     <= (stateNext == ST_DONE);
      err      <= (stateNext == ST_ERROR);
      imem_we  <= 1'b0;
      if (start) begin
        runXor       <= '0;
        words_loaded <= '0;
        err_code     <= ERR_NONE;
      end else if (accept) begin
        runXor <= runXor ^ in_data;
        case (state)
          ST_LEN_HI: lenHi <= in_data;
          ST_LEN_LO: begin
            wordTotal <= CNT_W'(lenWord);
            if (lenTooBig) err_code <= ERR_LEN;
          end
          ST_DATA_HI: dataHi <= in_data;
          ST_DATA_LO: begin
            imem_we      <= 1'b1;
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= {dataHi, in_data};
            words_loaded <= wordsInc;
          end
          ST_CSUM: begin
            if ((runXor ^ in_data) != 8'h00) err_code <= ERR_CSUM;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed vector table, hand-written corner
// sequences and randomized loads checked against a stream-level reference model.
module tb_prog_loader;

  localparam int unsigned ADDR_W = 8;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_run;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   words_loaded;

  always #5 CLK = ~CLK;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .busy(busy), .done(done), .err(err), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe seen, as {addr, data}.
  logic [23:0] gotWr[$];
  always @(negedge CLK) if (imem_we === 1'b1) gotWr.push_back({imem_addr, imem_wdata});

  // Reference: parse the stream by its rules and predict writes and verdict.
  task automatic modelLoad(input logic [7:0] bs[$], output logic [23:0] wr[$],
                           output logic expDone, output logic [1:0] expCode, output int expWords);
    int n;
    logic [7:0] x;
    wr.delete();
    n = int'({bs[0], bs[1]});
    if (n > (1 << ADDR_W)) begin
      expDone  = 1'b0;
      expCode  = 2'b01;
      expWords = 0;
    end else begin
      for (int i = 0; i < n; i++) wr.push_back({8'(i), bs[2 + 2*i], bs[3 + 2*i]});
      x = 8'h00;
      for (int i = 0; i < 2*n + 3; i++) x ^= bs[i];
      expDone  = (x == 8'h00);
      expCode  = (x == 8'h00) ? 2'b00 : 2'b10;
      expWords = n;
    end
  endtask

  // Pulse start, then offer the bytes; returns on the negedge right after the last accept.
  task automatic runLoad(input logic [7:0] bs[$], input int stallMode, input bit junkWithStart,
                         input bit clearWr);
    bit phase = 1'b0;
    bit ok = 1'b1;
    if (clearWr) gotWr.delete();
    @(negedge CLK);
    start = 1'b1; in_valid = junkWithStart; in_data = 8'h55;
    @(negedge CLK);
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < bs.size() && ok; i++) begin
      bit sent = 1'b0;
      int waits = 0;
      while (!sent && waits < 64) begin
        bit stall;
        phase = ~phase;
        stall = (stallMode == 1) ? !phase : (stallMode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
        if (stall) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data  = bs[i];
          sent     = (in_ready === 1'b1);
        end
        @(negedge CLK);
        waits++;
      end
      if (!sent) begin
        check($sformatf("handshake timeout byte %0d", i), 32'(in_ready), 32'd1);
        ok = 1'b0;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic expDone, input logic [1:0] expCode,
                             input int expWords, input logic [23:0] expWr[$]);
    check({tag, " done"},         32'(done),         32'(expDone));
    check({tag, " err"},          32'(err),          32'(!expDone));
    check({tag, " err_code"},     32'(err_code),     32'(expCode));
    check({tag, " cpu_run"},      32'(cpu_run),      32'(expDone));
    check({tag, " words_loaded"}, 32'(words_loaded), 32'(expWords));
    check({tag, " in_ready"},     32'(in_ready),     32'd0);
    check({tag, " busy"},         32'(busy),         32'd0);
    repeat (3) @(negedge CLK);
    check({tag, " done held"},    32'(done),         32'(expDone));
    check({tag, " write count"},  32'(gotWr.size()), 32'(expWr.size()));
    for (int i = 0; i < expWr.size() && i < gotWr.size(); i++)
      check($sformatf("%s write %0d", tag, i), 32'(gotWr[i]), 32'(expWr[i]));
  endtask

  task automatic checkResetVals(input string tag);
    check({tag, " in_ready"},     32'(in_ready),     32'd0);
    check({tag, " imem_we"},      32'(imem_we),      32'd0);
    check({tag, " cpu_run"},      32'(cpu_run),      32'd0);
    check({tag, " busy"},         32'(busy),         32'd0);
    check({tag, " done"},         32'(done),         32'd0);
    check({tag, " err"},          32'(err),          32'd0);
    check({tag, " imem_addr"},    32'(imem_addr),    32'd0);
    check({tag, " imem_wdata"},   32'(imem_wdata),   32'd0);
    check({tag, " err_code"},     32'(err_code),     32'd0);
    check({tag, " words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [7:0]  bytes[8];
    int          len;
    int          stall;
    logic        expDone;
    logic [1:0]  expCode;
    int          expWords;
    int          expNw;
    logic [23:0] expWr[2];
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0]  bs[$];
    logic [23:0] ew[$];
    logic        eDone;
    logic [1:0]  eCode;
    int          eWords;
    logic [15:0] nn;
    logic [7:0]  x, b;

    vecs[0] = '{"nominal",  '{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h42,8'h00}, 7, 0, 1'b1, 2'b00, 2, 2, '{24'h001234, 24'h01ABCD}};
    vecs[1] = '{"badcsum",  '{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h43,8'h00}, 7, 0, 1'b0, 2'b10, 2, 2, '{24'h001234, 24'h01ABCD}};
    vecs[2] = '{"overflow", '{8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 0, 1'b0, 2'b01, 0, 0, '{24'h0, 24'h0}};
    vecs[3] = '{"empty",    '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3, 0, 1'b1, 2'b00, 0, 0, '{24'h0, 24'h0}};
    vecs[4] = '{"stalled",  '{8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,8'h42,8'h00}, 7, 1, 1'b1, 2'b00, 2, 2, '{24'h001234, 24'h01ABCD}};
    vecs[5] = '{"ovf_ffff", '{8'hFF,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 2, 2, 1'b0, 2'b01, 0, 0, '{24'h0, 24'h0}};

    #2 RESET = 1'b0;
    #1 checkResetVals("por");
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    for (int v = 0; v < 6; v++) begin
      bs.delete(); ew.delete();
      for (int i = 0; i < vecs[v].len; i++) bs.push_back(vecs[v].bytes[i]);
      for (int i = 0; i < vecs[v].expNw; i++) ew.push_back(vecs[v].expWr[i]);
      runLoad(bs, vecs[v].stall, 1'b0, 1'b1);
      checkResult(vecs[v].name, vecs[v].expDone, vecs[v].expCode, vecs[v].expWords, ew);
    end

    // Asynchronous reset in the middle of a load.
    bs = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    runLoad(bs, 0, 1'b0, 1'b1);
    #2 RESET = 1'b0;
    #1 checkResetVals("midreset");
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check("restart in_ready before start", 32'(in_ready), 32'd0);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("restart in_ready after start", 32'(in_ready), 32'd1);
    check("restart busy after start", 32'(busy), 32'd1);

    // Start coincides with a valid byte while ready: the byte must be dropped.
    bs = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    runLoad(bs, 0, 1'b1, 1'b1);
    ew = '{24'h001234, 24'h01ABCD};
    checkResult("dropbyte", 1'b1, 2'b00, 2, ew);

    // Abort mid-load, then a full load rewrites from address 0.
    bs = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    runLoad(bs, 0, 1'b0, 1'b1);
    bs = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    runLoad(bs, 0, 1'b0, 1'b0);
    ew = '{24'h001234, 24'h001234, 24'h01ABCD};
    checkResult("abort", 1'b1, 2'b00, 2, ew);

    // Randomized loads; the first is forced to full capacity.
    for (int r = 0; r < 10; r++) begin
      int kind;
      bit bad;
      kind = (r == 0) ? 1 : int'($urandom_range(0, 9));
      bad  = ($urandom_range(0, 2) == 0);
      bs.delete();
      if (kind == 0)      nn = 16'($urandom_range(257, 65535));
      else if (kind == 1) nn = 16'd256;
      else                nn = 16'($urandom_range(0, 6));
      bs.push_back(nn[15:8]);
      bs.push_back(nn[7:0]);
      if (kind != 0) begin
        x = nn[15:8] ^ nn[7:0];
        for (int i = 0; i < 2*int'(nn); i++) begin
          b = 8'($urandom);
          x ^= b;
          bs.push_back(b);
        end
        if (bad) x ^= 8'($urandom_range(1, 255));
        bs.push_back(x);
      end
      modelLoad(bs, ew, eDone, eCode, eWords);
      runLoad(bs, int'($urandom_range(0, 2)), 1'b0, 1'b1);
      checkResult($sformatf("rand%0d n=%0d", r, nn), eDone, eCode, eWords, ew);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
